// File: rtl/controle_pkg.sv
// Shared control-word layout for the decoder, the pipeline control and the datapath.
package controle_pkg;

    localparam int CTRL_W  = 24;

    // Bit positions inside the 24-bit control word
    localparam int RW      = 23;
    localparam int OP_HI   = 22;
    localparam int OP_LO   = 21;
    localparam int OFFSET  = 20;
    localparam int MUX_IN  = 19;
    localparam int MUX_OUT = 18;
    localparam int MUX_WB  = 17;
    localparam int WR      = 16;
    localparam int MULT    = 15;
    localparam int RS_HI   = 14;
    localparam int RS_LO   = 10;
    localparam int RT_HI   = 9;
    localparam int RT_LO   = 5;
    localparam int RD_HI   = 4;
    localparam int RD_LO   = 0;

    typedef logic [CTRL_W-1:0] ctrl_word_t;
    typedef logic [4:0]        reg_idx_t;

    // Bubble word: WR=1 and MUX_ALU_Saida=1, everything else zero
    localparam ctrl_word_t CTRL_NOP = 24'h050000;

    function automatic reg_idx_t get_rs(input ctrl_word_t w);
        return w[RS_HI:RS_LO];
    endfunction

    function automatic reg_idx_t get_rt(input ctrl_word_t w);
        return w[RT_HI:RT_LO];
    endfunction

    function automatic reg_idx_t get_rd(input ctrl_word_t w);
        return w[RD_HI:RD_LO];
    endfunction

    // A load reads memory with an address offset; its Rt is a destination, not a source
    function automatic logic is_load(input ctrl_word_t w);
        return w[RW] & w[OFFSET];
    endfunction

endpackage

// File: rtl/controle_pipeline_detector_hazard.sv
// Load-use hazard compare between the word in EX and the word arriving from decode.
module detector_hazard
    import controle_pkg::*;
(
    input  logic [CTRL_W-1:0] ex_word,
    input  logic              ex_valid,
    input  logic [CTRL_W-1:0] in_word,
    input  logic              in_valid,
    input  logic              flush,
    output logic              hit
);

    logic     producer;
    logic     rs_match;
    logic     rt_match;
    reg_idx_t ex_rd;

    assign ex_rd = get_rd(ex_word);

    // EX holds a memory read that writes back to a real register ($0 never hazards)
    assign producer = ex_valid & ex_word[RW] & ex_word[MUX_WB] & (ex_rd != 5'd0);

    assign rs_match = (ex_rd == get_rs(in_word));
    // A consuming load only uses Rt as its destination, so Rt matches do not count
    assign rt_match = (ex_rd == get_rt(in_word)) & ~is_load(in_word);

    // Bubbles and flushed words never stall
    assign hit = producer & in_valid & ~flush & (rs_match | rt_match);

endmodule

// File: rtl/controle_pipeline.sv
// EX/MEM/WB control-word pipeline with load-use stall and multi-cycle MUL hold.
module controle_pipeline
    import controle_pkg::*;
#(
    parameter int MULT_LAT = 3,
    parameter int CW       = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] Controle,
    input  logic          Controle_valido,
    input  logic          Flush,
    output logic [CW-1:0] Controle_EX,
    output logic [CW-1:0] Controle_MEM,
    output logic [CW-1:0] Controle_WB,
    output logic          Valido_EX,
    output logic          Valido_MEM,
    output logic          Valido_WB,
    output logic          Parar,
    output logic          Mult_ocupado
);

    // Counter value loaded when a MUL enters EX; MULT_LAT=1 loads zero (no hold)
    localparam logic [2:0] HOLD_LOAD = 3'(MULT_LAT - 1);

    logic [CW-1:0] ex_reg, ex_next;
    logic [CW-1:0] mem_reg, mem_next;
    logic [CW-1:0] wb_reg, wb_next;
    logic          ex_val_reg, ex_val_next;
    logic          mem_val_reg, mem_val_next;
    logic          wb_val_reg, wb_val_next;
    logic [2:0]    cnt_reg, cnt_next;
    logic          hold;
    logic          hit;

    assign hold = (cnt_reg != 3'd0);

    detector_hazard u_detector_hazard (
        .ex_word  (ex_reg),
        .ex_valid (ex_val_reg),
        .in_word  (Controle),
        .in_valid (Controle_valido),
        .flush    (Flush),
        .hit      (hit)
    );

    // Next-state: MUL hold wins, then bubble insertion (invalid/flush/load-use), then advance
    always_comb begin
        ex_next      = ex_reg;
        ex_val_next  = ex_val_reg;
        mem_next     = ex_reg;
        mem_val_next = ex_val_reg;
        wb_next      = mem_reg;
        wb_val_next  = mem_val_reg;
        cnt_next     = cnt_reg;

        if (hold) begin
            // EX keeps the MUL; MEM receives bubbles; Flush is ignored here
            mem_next     = CTRL_NOP;
            mem_val_next = 1'b0;
            cnt_next     = cnt_reg - 3'd1;
        end else if (!Controle_valido || Flush || hit) begin
            ex_next     = CTRL_NOP;
            ex_val_next = 1'b0;
        end else begin
            ex_next     = Controle;
            ex_val_next = 1'b1;
            if (Controle[MULT]) begin
                cnt_next = HOLD_LOAD;
            end
        end
    end

    // Pipeline registers and MUL hold counter; reset aborts any hold immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_reg      <= CTRL_NOP;
            mem_reg     <= CTRL_NOP;
            wb_reg      <= CTRL_NOP;
            ex_val_reg  <= 1'b0;
            mem_val_reg <= 1'b0;
            wb_val_reg  <= 1'b0;
            cnt_reg     <= 3'd0;
        end else begin
            ex_reg      <= ex_next;
            mem_reg     <= mem_next;
            wb_reg      <= wb_next;
            ex_val_reg  <= ex_val_next;
            mem_val_reg <= mem_val_next;
            wb_val_reg  <= wb_val_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign Controle_EX  = ex_reg;
    assign Controle_MEM = mem_reg;
    assign Controle_WB  = wb_reg;
    assign Valido_EX    = ex_val_reg;
    assign Valido_MEM   = mem_val_reg;
    assign Valido_WB    = wb_val_reg;
    assign Parar        = hold | hit;
    assign Mult_ocupado = hold;

endmodule
